mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Arbitrates one single-port, variable-latency unified memory between the ARM pipeline's instruction-fetch port (IF stage) and data port (MEM stage). Sits between the pipeline and the memory: grants one requester at a time, drives the memory request/ack handshake, and returns per-port ready pulses that the top level uses to freeze the IF stage and the pipeline.

## Interface
- AW, 32, address width (byte address, passed through unmodified)
- DW, 32, data width
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- if_req  in  1  fetch request level, held until if_ready
- if_addr  in  AW  fetch address (PC), stable while if_req high
- if_rdata  out  DW  fetched instruction, valid with if_ready, held until next fetch completion
- if_ready  out  1  one-cycle pulse: fetch complete
- d_rd  in  1  data read request level, held until d_ready
- d_wr  in  1  data write request level, held until d_ready; d_rd and d_wr never both high
- d_addr  in  AW  data address, stable while request high
- d_wdata  in  DW  write data
- d_rdata  out  DW  read data, valid with d_ready, held until next data-read completion
- d_ready  out  1  one-cycle pulse: data access complete
- mem_req  out  1  memory request, held until mem_ack
- mem_we  out  1  write when 1
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid when mem_ack high
- mem_ack  in  1  one-cycle completion pulse from memory; may assert in the first mem_req cycle

## Operation
- States: IDLE, DATA, FETCH.
- IDLE: eligible requests are d_rd|d_wr with d_ready low, and if_req with if_ready low (a port whose ready is high this cycle is being retired and is not re-granted).
- Grant (default): data wins over fetch. Granted request loads mem_addr/mem_we/mem_wdata, sets mem_req, moves to DATA or FETCH.
- DATA/FETCH: hold mem_req and all mem_* outputs stable. On mem_ack: clear mem_req, capture mem_rdata into d_rdata (reads only) or if_rdata, pulse the matching ready next cycle, return to IDLE.
- Write completion leaves d_rdata unchanged; mem_wdata captured at grant.
- mem_ack while IDLE is ignored (no ready pulse, no state change).
- Requests that drop before completion: transaction still runs to mem_ack; ready pulses anyway.
- Reset values: state IDLE, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, if_rdata 0, d_rdata 0, if_ready 0, d_ready 0, last-grant flag = FETCH.
- Reset mid-transaction: immediate return to IDLE, mem_req low; any later ack ignored.

## Timing
- Cycle 0: request seen in IDLE, grant. Cycle 1: mem_req high. Cycle k≥1: mem_ack. Cycle k+1: ready pulse, state IDLE, new grant possible in same cycle for the other port.
- Minimum latency request→ready: 2 cycles (ack in cycle 1). Throughput: one access per 2 cycles minimum.
- All outputs registered; no combinational path from mem_ack/mem_rdata to any output.

## Configuration
- ARB_ROUND_ROBIN_EN defined: when both ports eligible in IDLE, grant the port not granted last (last-grant flag updated on every grant; reset value FETCH so data wins the first tie).
- Undefined: fixed priority, data always wins ties; last-grant flag absent.

## Structure
- Package arm_mem_pkg: arbiter state enum (IDLE/DATA/FETCH), grant-select encoding (GNT_DATA/GNT_FETCH), default AW/DW constants.
- One sub-module natural: mem_arb_select — combinational eligibility and priority/round-robin pick, ifdef confined there; FSM and datapath registers in the top.

## Test plan
- Lone fetch, if_addr=0x0000_0010, ack in first mem_req cycle, mem_rdata=0xE3A0_1005 -> mem_req cycle 1 only, if_ready pulse cycle 2, if_rdata=0xE3A0_1005.
- Data write d_addr=0x400, d_wdata=0xDEAD_BEEF, ack after 3 mem_req cycles -> mem_we=1, mem_addr/mem_wdata stable cycles 1-3, d_ready cycle 4, d_rdata unchanged.
- Simultaneous d_rd (0x404) and if_req (0x14) -> data granted first, d_ready pulse, fetch granted same cycle as d_ready, if_ready 2+ cycles later; with ARB_ROUND_ROBIN_EN, second tie goes to fetch first.
- Requests held high through ready cycle -> no duplicate grant of the retiring port; held request after ready cycle starts a new transaction.
- Spurious mem_ack in IDLE -> no ready pulse, state stays IDLE.
- rst low during FETCH with mem_ack pending -> mem_req 0 and all outputs at reset values asynchronously; late ack after release ignored.

Source files
------------

// File: rtl/arm_mem_pkg.sv
// Shared types and defaults for the IF/MEM unified-memory port arbiter.
// Optional build macro ARB_ROUND_ROBIN_EN is consumed by mem_arb_select only.
package arm_mem_pkg;

  localparam int unsigned DefaultAw = 32;
  localparam int unsigned DefaultDw = 32;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StFetch
  } arb_state_e;

  typedef enum logic {
    GntData,
    GntFetch
  } gnt_sel_e;

endpackage

// File: rtl/mem_arb_select.sv
// Eligibility and grant pick for the memory arbiter.
// ARB_ROUND_ROBIN_EN: alternate on ties using a last-grant flag; otherwise data always wins.
module mem_arb_select
  import arm_mem_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     idle,
  input  logic     d_rd,
  input  logic     d_wr,
  input  logic     d_ready,
  input  logic     if_req,
  input  logic     if_ready,
  output logic     gnt_valid,
  output gnt_sel_e gnt_sel
);

  logic d_elig;
  logic f_elig;

  // A port whose ready pulse is high this cycle is retiring and must not be re-granted.
  assign d_elig    = (d_rd | d_wr) & ~d_ready;
  assign f_elig    = if_req & ~if_ready;
  assign gnt_valid = idle & (d_elig | f_elig);

`ifdef ARB_ROUND_ROBIN_EN
  gnt_sel_e last_gnt_q;

  always_comb begin
    if (d_elig && f_elig) begin
      gnt_sel = (last_gnt_q == GntFetch) ? GntData : GntFetch;
    end else if (d_elig) begin
      gnt_sel = GntData;
    end else begin
      gnt_sel = GntFetch;
    end
  end

  // Reset to fetch so data takes the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_gnt_q <= GntFetch;
    end else if (gnt_valid) begin
      last_gnt_q <= gnt_sel;
    end
  end
`else
  logic unused_rr;
  assign unused_rr = ^{clk, rst};
  assign gnt_sel   = d_elig ? GntData : GntFetch;
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between the IF fetch port and the MEM data port.
// Tie policy set by ARB_ROUND_ROBIN_EN (see mem_arb_select); all outputs are registered.
module mem_port_arbiter
  import arm_mem_pkg::*;
#(
  parameter int unsigned AW = DefaultAw,
  parameter int unsigned DW = DefaultDw
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_ready,
  input  logic          d_rd,
  input  logic          d_wr,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic [DW-1:0] d_rdata,
  output logic          d_ready,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack
);

  arb_state_e state_q;
  logic       idle;
  logic       gnt_valid;
  gnt_sel_e   gnt_sel;

  assign idle = (state_q == StIdle);

  mem_arb_select u_select (
    .clk      (clk),
    .rst      (rst),
    .idle     (idle),
    .d_rd     (d_rd),
    .d_wr     (d_wr),
    .d_ready  (d_ready),
    .if_req   (if_req),
    .if_ready (if_ready),
    .gnt_valid(gnt_valid),
    .gnt_sel  (gnt_sel)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_ready  <= 1'b0;
      d_ready   <= 1'b0;
    end else begin
      if_ready <= 1'b0;
      d_ready  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // An ack arriving here is stale and deliberately ignored.
          if (gnt_valid) begin
            mem_req <= 1'b1;
            if (gnt_sel == GntData) begin
              state_q   <= StData;
              mem_we    <= d_wr;
              mem_addr  <= d_addr;
              mem_wdata <= d_wdata;
            end else begin
              state_q  <= StFetch;
              mem_we   <= 1'b0;
              mem_addr <= if_addr;
            end
          end
        end
        StData: begin
          if (mem_ack) begin
            state_q <= StIdle;
            mem_req <= 1'b0;
            d_ready <= 1'b1;
            if (!mem_we) begin
              d_rdata <= mem_rdata;
            end
          end
        end
        StFetch: begin
          if (mem_ack) begin
            state_q  <= StIdle;
            mem_req  <= 1'b0;
            if_ready <= 1'b1;
            if_rdata <= mem_rdata;
          end
        end
        default: begin
          state_q <= StIdle;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter; tie expectations follow ARB_ROUND_ROBIN_EN.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_ready;
  logic          d_rd;
  logic          d_wr;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_ack;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(
    .AW(AW),
    .DW(DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_ready (if_ready),
    .d_rd     (d_rd),
    .d_wr     (d_wr),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_ready  (d_ready),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Both ports request together; data_first selects which one the arbiter should serve first.
  task automatic run_tie(input string tag, input bit data_first,
                         input logic [DW-1:0] dval, input logic [DW-1:0] fval);
    d_rd    = 1'b1;
    d_addr  = 32'h0000_0404;
    if_req  = 1'b1;
    if_addr = 32'h0000_0014;
    tick();
    check({tag, "_req1"}, mem_req, 1);
    check({tag, "_addr1"}, mem_addr, data_first ? 32'h404 : 32'h14);
    mem_ack   = 1'b1;
    mem_rdata = data_first ? dval : fval;
    tick();
    mem_ack = 1'b0;
    check({tag, "_req_clr"}, mem_req, 0);
    if (data_first) begin
      check({tag, "_d_ready1"}, {d_ready, if_ready}, 2'b10);
      check({tag, "_d_rdata"}, d_rdata, dval);
      d_rd = 1'b0;
    end else begin
      check({tag, "_if_ready1"}, {d_ready, if_ready}, 2'b01);
      check({tag, "_if_rdata"}, if_rdata, fval);
      if_req = 1'b0;
    end
    tick();
    // Other port granted in the ready cycle, so mem_req is back already.
    check({tag, "_req2"}, mem_req, 1);
    check({tag, "_addr2"}, mem_addr, data_first ? 32'h14 : 32'h404);
    check({tag, "_no_ready"}, {d_ready, if_ready}, 2'b00);
    mem_ack   = 1'b1;
    mem_rdata = data_first ? fval : dval;
    tick();
    mem_ack = 1'b0;
    if (data_first) begin
      check({tag, "_if_ready2"}, {d_ready, if_ready}, 2'b01);
      check({tag, "_if_rdata2"}, if_rdata, fval);
    end else begin
      check({tag, "_d_ready2"}, {d_ready, if_ready}, 2'b10);
      check({tag, "_d_rdata2"}, d_rdata, dval);
    end
    d_rd   = 1'b0;
    if_req = 1'b0;
    tick();
  endtask

  initial begin
    rst       = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    d_rd      = 1'b0;
    d_wr      = 1'b0;
    d_addr    = '0;
    d_wdata   = '0;
    mem_rdata = '0;
    mem_ack   = 1'b0;
    #2;
    check("rst_ctrl", {mem_req, mem_we, if_ready, d_ready}, 4'b0000);
    check("rst_addr", {mem_addr, mem_wdata}, 64'h0);
    check("rst_rdata", {if_rdata, d_rdata}, 64'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // First tie after reset: data wins in both builds.
    run_tie("tie1", 1'b1, 32'h1111_2222, 32'h3333_4444);

    // Lone fetch, ack in the first mem_req cycle.
    if_req  = 1'b1;
    if_addr = 32'h0000_0010;
    tick();
    check("lf_req", {mem_req, mem_we}, 2'b10);
    check("lf_addr", mem_addr, 32'h10);
    mem_ack   = 1'b1;
    mem_rdata = 32'hE3A0_1005;
    tick();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    if_req    = 1'b0;
    check("lf_ready", {mem_req, if_ready, d_ready}, 3'b010);
    check("lf_rdata", if_rdata, 32'hE3A0_1005);
    tick();
    check("lf_ready_drop", if_ready, 0);

    // Data write, ack after three mem_req cycles.
    d_wr    = 1'b1;
    d_addr  = 32'h0000_0400;
    d_wdata = 32'hDEAD_BEEF;
    tick();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("wr_hold%0d", i), {mem_req, mem_we, d_ready}, 3'b110);
      check($sformatf("wr_bus%0d", i), {mem_addr, mem_wdata}, {32'h400, 32'hDEAD_BEEF});
      if (i == 2) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
      end
      tick();
    end
    mem_ack = 1'b0;
    d_wr    = 1'b0;
    check("wr_ready", {mem_req, d_ready}, 2'b01);
    check("wr_rdata_kept", d_rdata, 32'h1111_2222);
    tick();

    // Second tie: last grant was data, so round robin favours fetch.
`ifdef ARB_ROUND_ROBIN_EN
    run_tie("tie2", 1'b0, 32'h5555_6666, 32'h7777_8888);
`else
    run_tie("tie2", 1'b1, 32'h5555_6666, 32'h7777_8888);
`endif

    // Read request held through its ready cycle.
    d_rd   = 1'b1;
    d_addr = 32'h0000_0500;
    tick();
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0055;
    tick();
    mem_ack = 1'b0;
    check("hold_ready", {mem_req, d_ready}, 2'b01);
    tick();
    check("hold_no_dup", {mem_req, d_ready}, 2'b00);
    tick();
    check("hold_regrant", {mem_req, mem_addr}, {1'b1, 32'h500});
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0066;
    tick();
    mem_ack = 1'b0;
    d_rd    = 1'b0;
    check("hold_ready2", d_ready, 1);
    check("hold_rdata2", d_rdata, 32'h66);
    tick();

    // Spurious ack while idle.
    mem_ack   = 1'b1;
    mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    check("spur_ready", {mem_req, if_ready, d_ready}, 3'b000);
    check("spur_rdata", {if_rdata, d_rdata}, {32'h7777_8888, 32'h66});
    tick();

    // Fetch started, then reset mid-transaction with an ack pending.
    if_req  = 1'b1;
    if_addr = 32'h0000_0020;
    tick();
    check("rf_idle_grant", {mem_req, mem_addr}, {1'b1, 32'h20});
    tick();
    check("rf_held", mem_req, 1);
    mem_ack = 1'b1;
    #2;
    rst    = 1'b0;
    if_req = 1'b0;
    #1;
    check("rf_async_ctrl", {mem_req, mem_we, if_ready, d_ready}, 4'b0000);
    check("rf_async_bus", {mem_addr, mem_wdata}, 64'h0);
    check("rf_async_rdata", {if_rdata, d_rdata}, 64'h0);
    tick();
    rst = 1'b1;
    tick();
    mem_ack = 1'b0;
    check("rf_late_ack", {mem_req, if_ready, d_ready}, 3'b000);
    check("rf_late_rdata", if_rdata, 32'h0);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
